// File: rtl/mips_pkg.sv
// Shared encodings, control word layout and decode helpers for the pipelined control unit.
// Pure declarations and functions; no clocked logic.
// No flow control of its own.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_JR    = 6'h08;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;

    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_SUB = 4'b0001;
    localparam logic [3:0] ALUOP_OR  = 4'b0010;
    localparam logic [3:0] ALUOP_LUI = 4'b0011;
    localparam logic [3:0] ALUOP_SLL = 4'b0100;
    localparam logic [3:0] ALUOP_SRL = 4'b0101;
    localparam logic [3:0] ALUOP_AND = 4'b0110;
    localparam logic [3:0] ALUOP_XOR = 4'b0111;

    localparam logic [2:0] MDOP_MULT  = 3'b000;
    localparam logic [2:0] MDOP_MULTU = 3'b001;
    localparam logic [2:0] MDOP_DIV   = 3'b010;
    localparam logic [2:0] MDOP_DIVU  = 3'b011;
    localparam logic [2:0] MDOP_MTHI  = 3'b100;
    localparam logic [2:0] MDOP_MTLO  = 3'b101;

    localparam logic [1:0] RWD_ALU  = 2'b00;
    localparam logic [1:0] RWD_DM   = 2'b01;
    localparam logic [1:0] RWD_PC8  = 2'b10;
    localparam logic [1:0] RWD_HILO = 2'b11;

    localparam logic [1:0] PCOP_PC4 = 2'b00;
    localparam logic [1:0] PCOP_NPC = 2'b01;
    localparam logic [1:0] PCOP_JR  = 2'b10;

    // TUSE_NONE exceeds every Tnew, so an unread field can never stall.
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    // Control word carried down E/M/W; all-zero is a nop.
    typedef struct packed {
        logic [4:0] a3;
        logic       alu_src;
        logic [3:0] aluop;
        logic [2:0] mdop;
        logic       md_start;
        logic       md_div;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] rwd;
        logic       hilo_sel;
        logic [1:0] tnew;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Full decode of the instruction in D: D-only fields plus the word sent to E.
    typedef struct packed {
        ctrl_t      ctrl;
        logic [1:0] pcop;
        logic       extop;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       md_class;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic equal);
        dec_t       d;
        logic       r_alu;
        logic       i_alu;
        logic [3:0] alu_op;
        d         = '0;
        d.tuse_rs = TUSE_NONE;
        d.tuse_rt = TUSE_NONE;
        r_alu     = 1'b0;
        i_alu     = 1'b0;
        alu_op    = ALUOP_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: begin r_alu = 1'b1; alu_op = ALUOP_ADD; end
                    FUNCT_SUB, FUNCT_SUBU: begin r_alu = 1'b1; alu_op = ALUOP_SUB; end
                    FUNCT_AND:             begin r_alu = 1'b1; alu_op = ALUOP_AND; end
                    FUNCT_OR:              begin r_alu = 1'b1; alu_op = ALUOP_OR;  end
                    FUNCT_XOR:             begin r_alu = 1'b1; alu_op = ALUOP_XOR; end
                    FUNCT_SLL:             begin r_alu = 1'b1; alu_op = ALUOP_SLL; end
                    FUNCT_SRL:             begin r_alu = 1'b1; alu_op = ALUOP_SRL; end
                    FUNCT_JR: begin
                        d.pcop    = PCOP_JR;
                        d.tuse_rs = TUSE_0;
                    end
                    FUNCT_MFHI, FUNCT_MFLO: begin
                        d.ctrl.a3       = rd;
                        d.ctrl.rwd      = RWD_HILO;
                        d.ctrl.hilo_sel = (funct == FUNCT_MFLO);
                        d.ctrl.tnew     = TNEW_1;
                        d.md_class      = 1'b1;
                    end
                    FUNCT_MTHI, FUNCT_MTLO: begin
                        d.ctrl.mdop = (funct == FUNCT_MTHI) ? MDOP_MTHI : MDOP_MTLO;
                        d.tuse_rs   = TUSE_1;
                        d.md_class  = 1'b1;
                    end
                    FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                        d.ctrl.mdop     = {1'b0, funct[1:0]};
                        d.ctrl.md_start = 1'b1;
                        d.ctrl.md_div   = funct[1];
                        d.tuse_rs       = TUSE_1;
                        d.tuse_rt       = TUSE_1;
                        d.md_class      = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin i_alu = 1'b1; alu_op = ALUOP_ADD; d.extop = 1'b1; end
            OP_ANDI:           begin i_alu = 1'b1; alu_op = ALUOP_AND; end
            OP_ORI:            begin i_alu = 1'b1; alu_op = ALUOP_OR;  end
            OP_XORI:           begin i_alu = 1'b1; alu_op = ALUOP_XOR; end
            OP_LUI:            begin i_alu = 1'b1; alu_op = ALUOP_LUI; end
            OP_LW: begin
                d.ctrl.a3      = rt;
                d.ctrl.alu_src = 1'b1;
                d.ctrl.rwd     = RWD_DM;
                d.ctrl.tnew    = TNEW_2;
                d.extop        = 1'b1;
                d.tuse_rs      = TUSE_1;
            end
            OP_SW: begin
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.mem_write = 1'b1;
                d.extop          = 1'b1;
                d.tuse_rs        = TUSE_1;
                d.tuse_rt        = TUSE_2;
            end
            OP_BEQ, OP_BNE: begin
                d.pcop    = ((op == OP_BEQ) == equal) ? PCOP_NPC : PCOP_PC4;
                d.extop   = 1'b1;
                d.tuse_rs = TUSE_0;
                d.tuse_rt = TUSE_0;
            end
            OP_J:  d.pcop = PCOP_NPC;
            OP_JAL: begin
                d.pcop      = PCOP_NPC;
                d.ctrl.a3   = 5'd31;
                d.ctrl.rwd  = RWD_PC8;
                d.ctrl.tnew = TNEW_0;
            end
            default: ;
        endcase
        if (r_alu) begin
            d.ctrl.a3    = rd;
            d.ctrl.aluop = alu_op;
            d.ctrl.tnew  = TNEW_1;
            d.tuse_rs    = TUSE_1;
            d.tuse_rt    = TUSE_1;
        end
        if (i_alu) begin
            d.ctrl.a3      = rt;
            d.ctrl.alu_src = 1'b1;
            d.ctrl.aluop   = alu_op;
            d.ctrl.tnew    = TNEW_1;
            d.tuse_rs      = TUSE_1;
        end
        d.ctrl.reg_write = (d.ctrl.a3 != 5'd0);
        return d;
    endfunction

    // A source read too early for a producer still in flight.
    function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] a3, input logic [1:0] tnew);
        return (src != 5'd0) && (src == a3) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the datapath and the pipelined control unit.
// Wires only; no latency.
// No handshake: stall is the only hold signal and is carried here.
interface pipe_ctrl_if;
    logic [31:0] instr_D;
    logic        equal_D;
    logic [1:0]  PCOP_D;
    logic        ExtOP_D;
    logic        stall;
    logic [4:0]  A3_E;
    logic [4:0]  A3_M;
    logic [4:0]  A3_W;
    logic        ALUSrc_E;
    logic [3:0]  ALUOP_E;
    logic [2:0]  MDOP_E;
    logic        md_start_E;
    logic        MemWrite_M;
    logic        RegWrite_W;
    logic [1:0]  RegWData_W;
    logic        HiLoSel_W;
    logic        md_busy;

    modport master (
        output instr_D, equal_D,
        input  PCOP_D, ExtOP_D, stall, A3_E, A3_M, A3_W, ALUSrc_E, ALUOP_E, MDOP_E,
               md_start_E, MemWrite_M, RegWrite_W, RegWData_W, HiLoSel_W, md_busy
    );

    modport slave (
        input  instr_D, equal_D,
        output PCOP_D, ExtOP_D, stall, A3_E, A3_M, A3_W, ALUSrc_E, ALUOP_E, MDOP_E,
               md_start_E, MemWrite_M, RegWrite_W, RegWData_W, HiLoSel_W, md_busy
    );
endinterface

// File: rtl/md_busy_counter.sv
// Tracks occupancy of the multi-cycle mult/div unit with a down-counter.
// busy rises the cycle after start and stays high MULT_CYCLES or DIV_CYCLES cycles.
// Ignores pipeline stall; reset abandons any operation in progress.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    logic [CNT_W-1:0] cnt;

    // Load on start, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/pipe_ctrl.sv
// Decodes instr_D and pipes the control word through E/M/W; detects RAW and mult/div hazards.
// D outputs combinational; E/M/W outputs registered one, two and three edges after D.
// stall holds PC and F/D and injects a nop into E; M and W always advance.
module pipe_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);
    import mips_pkg::*;

    dec_t       dec_d;
    ctrl_t      ctrl_e;
    ctrl_t      ctrl_m;
    ctrl_t      ctrl_w;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [1:0] tnew_m;
    logic       stall_raw;
    logic       stall_md;
    logic       md_busy;
    logic       unused_bits;

    assign rs_d = bus.instr_D[25:21];
    assign rt_d = bus.instr_D[20:16];

    // Combinational decode of the instruction sitting in D.
    always_comb begin
        dec_d = decode(bus.instr_D[31:26], bus.instr_D[5:0], rt_d, bus.instr_D[15:11],
                       bus.equal_D);
    end

    // Hazard detection: Tuse/Tnew against E and M, plus mult/div occupancy.
    always_comb begin
        tnew_m    = (ctrl_m.tnew == TNEW_0) ? TNEW_0 : ctrl_m.tnew - 2'd1;
        stall_raw = raw_hit(rs_d, dec_d.tuse_rs, ctrl_e.a3, ctrl_e.tnew)
                  | raw_hit(rt_d, dec_d.tuse_rt, ctrl_e.a3, ctrl_e.tnew)
                  | raw_hit(rs_d, dec_d.tuse_rs, ctrl_m.a3, tnew_m)
                  | raw_hit(rt_d, dec_d.tuse_rt, ctrl_m.a3, tnew_m);
        stall_md  = dec_d.md_class && (ctrl_e.md_start || md_busy);
    end

    // Control pipeline: a stalled D leaves a bubble in E.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_e <= CTRL_NOP;
            ctrl_m <= CTRL_NOP;
            ctrl_w <= CTRL_NOP;
        end else begin
            ctrl_e <= (stall_raw || stall_md) ? CTRL_NOP : dec_d.ctrl;
            ctrl_m <= ctrl_e;
            ctrl_w <= ctrl_m;
        end
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy (
        .clk    (clk),
        .reset  (reset),
        .start  (ctrl_e.md_start),
        .is_div (ctrl_e.md_div),
        .busy   (md_busy)
    );

    assign bus.PCOP_D     = dec_d.pcop;
    assign bus.ExtOP_D    = dec_d.extop;
    assign bus.stall      = stall_raw | stall_md;
    assign bus.A3_E       = ctrl_e.a3;
    assign bus.A3_M       = ctrl_m.a3;
    assign bus.A3_W       = ctrl_w.a3;
    assign bus.ALUSrc_E   = ctrl_e.alu_src;
    assign bus.ALUOP_E    = ctrl_e.aluop;
    assign bus.MDOP_E     = ctrl_e.mdop;
    assign bus.md_start_E = ctrl_e.md_start;
    assign bus.MemWrite_M = ctrl_m.mem_write;
    assign bus.RegWrite_W = ctrl_w.reg_write;
    assign bus.RegWData_W = ctrl_w.rwd;
    assign bus.HiLoSel_W  = ctrl_w.hilo_sel;
    assign bus.md_busy    = md_busy;

    // Shamt and the E/M-only fields of the W word are not needed by this block.
    assign unused_bits = ^{bus.instr_D[10:6], ctrl_w.alu_src, ctrl_w.aluop, ctrl_w.mdop,
                           ctrl_w.md_start, ctrl_w.md_div, ctrl_w.mem_write, ctrl_w.tnew};
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-instruction decode table plus hazard sequences.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// All waits are bounded clock counts; a watchdog ends the run if time runs away.
module tb_pipe_ctrl;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] instr;
        logic        eq;
        logic [1:0]  pcop;
        logic        extop;
        logic [4:0]  a3;
        logic        alusrc;
        logic [3:0]  aluop;
        logic [2:0]  mdop;
        logic        start;
        logic        memw;
        logic        regw;
        logic [1:0]  rwd;
        logic        hilo;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] prog[$];
    logic        stall_l [32];
    logic        start_l [32];
    logic        busy_l  [32];
    logic [1:0]  pcop_l  [32];
    logic [4:0]  a3e_l   [32];
    logic [4:0]  a3w_l   [32];
    logic        regw_l  [32];
    logic [1:0]  rwd_l   [32];
    logic        hilo_l  [32];

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic eq, input logic [1:0] pcop,
                                input logic extop, input logic [4:0] a3, input logic alusrc,
                                input logic [3:0] aluop, input logic [2:0] mdop,
                                input logic start, input logic memw, input logic regw,
                                input logic [1:0] rwd, input logic hilo);
        vec_t v;
        v = {instr, eq, pcop, extop, a3, alusrc, aluop, mdop, start, memw, regw, rwd, hilo};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bus.instr_D = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Emulates fetch: D holds while stall is high, else the next prog word enters.
    task automatic run_prog(input int ncyc, output int stalls);
        int idx;
        idx    = 0;
        stalls = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            bus.instr_D = (idx < prog.size()) ? prog[idx] : 32'h0;
            #1;
            stall_l[c] = bus.stall;
            start_l[c] = bus.md_start_E;
            busy_l[c]  = bus.md_busy;
            pcop_l[c]  = bus.PCOP_D;
            a3e_l[c]   = bus.A3_E;
            a3w_l[c]   = bus.A3_W;
            regw_l[c]  = bus.RegWrite_W;
            rwd_l[c]   = bus.RegWData_W;
            hilo_l[c]  = bus.HiLoSel_W;
            if (bus.stall) stalls++;
            else idx++;
        end
    endtask

    function automatic int count_ones(input int ncyc, input int which);
        int n;
        n = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (which == 0 && stall_l[c]) n++;
            if (which == 1 && start_l[c]) n++;
            if (which == 2 && busy_l[c])  n++;
        end
        return n;
    endfunction

    initial begin
        int st;
        tests       = 0;
        failed      = 0;
        reset       = 1'b1;
        bus.instr_D = 32'h0;
        bus.equal_D = 1'b0;

        // instr, eq, pcop, extop, a3, alusrc, aluop, mdop, start, memw, regw, rwd, hilo
        vecs.push_back(mk(enc_r(1, 2, 3, 6'h21),            0, 2'b00, 0, 5'd3,  0, 4'b0000, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_r(6, 7, 5, 6'h23),            0, 2'b00, 0, 5'd5,  0, 4'b0001, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_r(1, 2, 12, 6'h24),           0, 2'b00, 0, 5'd12, 0, 4'b0110, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_r(1, 2, 11, 6'h26),           0, 2'b00, 0, 5'd11, 0, 4'b0111, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_r(0, 2, 10, 6'h00) | 32'h0c0, 0, 2'b00, 0, 5'd10, 0, 4'b0100, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_r(0, 2, 13, 6'h02),           0, 2'b00, 0, 5'd13, 0, 4'b0101, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_i(6'h0d, 2, 4, 16'h00ff),     0, 2'b00, 0, 5'd4,  1, 4'b0010, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_i(6'h0f, 0, 6, 16'h1234),     0, 2'b00, 0, 5'd6,  1, 4'b0011, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_i(6'h09, 1, 14, 16'hfff0),    0, 2'b00, 1, 5'd14, 1, 4'b0000, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_i(6'h0e, 1, 15, 16'h0f0f),    0, 2'b00, 0, 5'd15, 1, 4'b0111, 3'b000, 0, 0, 1, 2'b00, 0));
        vecs.push_back(mk(enc_i(6'h23, 1, 7, 16'h0004),     0, 2'b00, 1, 5'd7,  1, 4'b0000, 3'b000, 0, 0, 1, 2'b01, 0));
        vecs.push_back(mk(enc_i(6'h2b, 1, 2, 16'h0008),     0, 2'b00, 1, 5'd0,  1, 4'b0000, 3'b000, 0, 1, 0, 2'b00, 0));
        vecs.push_back(mk(enc_i(6'h04, 1, 2, 16'h0003),     1, 2'b01, 1, 5'd0,  0, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(enc_i(6'h04, 1, 2, 16'h0003),     0, 2'b00, 1, 5'd0,  0, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(enc_i(6'h05, 1, 2, 16'h0003),     0, 2'b01, 1, 5'd0,  0, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(enc_i(6'h05, 1, 2, 16'h0003),     1, 2'b00, 1, 5'd0,  0, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk({6'h02, 26'h0000100},             0, 2'b01, 0, 5'd0,  0, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk({6'h03, 26'h0000100},             0, 2'b01, 0, 5'd31, 0, 4'b0000, 3'b000, 0, 0, 1, 2'b10, 0));
        vecs.push_back(mk(enc_r(31, 0, 0, 6'h08),           0, 2'b10, 0, 5'd0,  0, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(enc_r(1, 2, 0, 6'h18),            0, 2'b00, 0, 5'd0,  0, 4'b0000, 3'b000, 1, 0, 0, 2'b00, 0));
        vecs.push_back(mk(enc_r(1, 2, 0, 6'h1b),            0, 2'b00, 0, 5'd0,  0, 4'b0000, 3'b011, 1, 0, 0, 2'b00, 0));
        vecs.push_back(mk(enc_r(1, 0, 0, 6'h11),            0, 2'b00, 0, 5'd0,  0, 4'b0000, 3'b100, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(enc_r(1, 0, 0, 6'h13),            0, 2'b00, 0, 5'd0,  0, 4'b0000, 3'b101, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(enc_r(0, 0, 8, 6'h10),            0, 2'b00, 0, 5'd8,  0, 4'b0000, 3'b000, 0, 0, 1, 2'b11, 0));
        vecs.push_back(mk(enc_r(0, 0, 9, 6'h12),            0, 2'b00, 0, 5'd9,  0, 4'b0000, 3'b000, 0, 0, 1, 2'b11, 1));
        vecs.push_back(mk({6'h3f, 26'h3ffffff},             1, 2'b00, 0, 5'd0,  0, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(enc_r(1, 2, 3, 6'h3f),            1, 2'b00, 0, 5'd0,  0, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0));

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset stall", bus.stall, 0);
        check("reset md_busy", bus.md_busy, 0);
        check("reset A3_E", bus.A3_E, 0);
        check("reset A3_M", bus.A3_M, 0);
        check("reset A3_W", bus.A3_W, 0);
        check("reset md_start_E", bus.md_start_E, 0);
        check("reset RegWrite_W", bus.RegWrite_W, 0);

        // Per-instruction decode and propagation, each from a clean pipeline
        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            @(negedge clk);
            bus.instr_D = vecs[i].instr;
            bus.equal_D = vecs[i].eq;
            #1;
            check($sformatf("v%0d PCOP_D", i), bus.PCOP_D, vecs[i].pcop);
            check($sformatf("v%0d ExtOP_D", i), bus.ExtOP_D, vecs[i].extop);
            check($sformatf("v%0d stall", i), bus.stall, 0);
            @(negedge clk);
            bus.instr_D = 32'h0;
            #1;
            check($sformatf("v%0d A3_E", i), bus.A3_E, vecs[i].a3);
            check($sformatf("v%0d ALUSrc_E", i), bus.ALUSrc_E, vecs[i].alusrc);
            check($sformatf("v%0d ALUOP_E", i), bus.ALUOP_E, vecs[i].aluop);
            check($sformatf("v%0d MDOP_E", i), bus.MDOP_E, vecs[i].mdop);
            check($sformatf("v%0d md_start_E", i), bus.md_start_E, vecs[i].start);
            @(negedge clk);
            #1;
            check($sformatf("v%0d MemWrite_M", i), bus.MemWrite_M, vecs[i].memw);
            check($sformatf("v%0d A3_M", i), bus.A3_M, vecs[i].a3);
            @(negedge clk);
            #1;
            check($sformatf("v%0d A3_W", i), bus.A3_W, vecs[i].a3);
            check($sformatf("v%0d RegWrite_W", i), bus.RegWrite_W, vecs[i].regw);
            check($sformatf("v%0d RegWData_W", i), bus.RegWData_W, vecs[i].rwd);
            check($sformatf("v%0d HiLoSel_W", i), bus.HiLoSel_W, vecs[i].hilo);
        end
        bus.equal_D = 1'b0;

        // lw then dependent addu: one bubble
        do_reset();
        prog = '{enc_i(6'h23, 0, 1, 16'h0), enc_r(1, 1, 2, 6'h21)};
        run_prog(6, st);
        check("lw-addu stall count", st, 1);
        check("lw-addu stall at c1", stall_l[1], 1);
        check("lw-addu A3_E at c3", a3e_l[3], 2);

        // lw then dependent beq: two bubbles, then branch taken
        do_reset();
        bus.equal_D = 1'b1;
        prog = '{enc_i(6'h23, 0, 1, 16'h0), enc_i(6'h04, 1, 0, 16'h2)};
        run_prog(6, st);
        check("lw-beq stall count", st, 2);
        check("lw-beq stall at c1", stall_l[1], 1);
        check("lw-beq stall at c2", stall_l[2], 1);
        check("lw-beq PCOP_D at c3", pcop_l[3], 2'b01);
        bus.equal_D = 1'b0;

        // Writes to $0 never create hazards and never write back
        do_reset();
        prog = '{enc_r(3, 3, 0, 6'h21), enc_r(0, 0, 4, 6'h21)};
        run_prog(6, st);
        check("r0 stall count", st, 0);
        check("r0 RegWrite_W first", regw_l[3], 0);
        check("r0 A3_W first", a3w_l[3], 0);
        check("r0 RegWrite_W second", regw_l[4], 1);
        check("r0 A3_W second", a3w_l[4], 4);

        // mult then mflo: start pulse then 1+MULT_CYCLES stall cycles
        do_reset();
        prog = '{enc_r(1, 2, 0, 6'h18), enc_r(0, 0, 3, 6'h12)};
        run_prog(14, st);
        check("mult stall count", st, 6);
        check("mult start count", count_ones(14, 1), 1);
        check("mult busy count", count_ones(14, 2), 5);
        check("mult stall at c6", stall_l[6], 1);
        check("mult stall at c7", stall_l[7], 0);
        check("mflo A3_W", a3w_l[10], 3);
        check("mflo RegWData_W", rwd_l[10], 2'b11);
        check("mflo HiLoSel_W", hilo_l[10], 1);
        check("mflo RegWrite_W", regw_l[10], 1);

        // div then mfhi: 1+DIV_CYCLES stall cycles
        do_reset();
        prog = '{enc_r(1, 2, 0, 6'h1a), enc_r(0, 0, 8, 6'h10)};
        run_prog(16, st);
        check("div stall count", st, 11);
        check("div busy count", count_ones(16, 2), 10);

        // jal then sw of $31: Tnew 0 producer, no stall
        do_reset();
        prog = '{{6'h03, 26'h0000040}, enc_i(6'h2b, 0, 31, 16'h0)};
        run_prog(6, st);
        check("jal-sw stall count", st, 0);
        check("jal A3_E", a3e_l[1], 31);
        check("jal A3_W", a3w_l[3], 31);
        check("jal RegWData_W", rwd_l[3], 2'b10);

        // lw then sw storing the loaded register: Tuse 2 equals Tnew 2, no stall
        do_reset();
        prog = '{enc_i(6'h23, 0, 1, 16'h0), enc_i(6'h2b, 2, 1, 16'h0)};
        run_prog(6, st);
        check("lw-sw stall count", st, 0);

        // Reset during div busy cycle 4 with live E/M/W contents
        do_reset();
        @(negedge clk);
        bus.instr_D = enc_r(1, 2, 0, 6'h1a);
        @(negedge clk);
        bus.instr_D = enc_r(6, 7, 5, 6'h21);
        #1;
        check("div-reset md_start_E", bus.md_start_E, 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("div-reset busy cycle %0d", c), bus.md_busy, 1);
        end
        check("div-reset A3_M before", bus.A3_M, 5);
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bus.instr_D = enc_r(0, 0, 8, 6'h10);
        #1;
        check("div-reset md_busy", bus.md_busy, 0);
        check("div-reset stall", bus.stall, 0);
        check("div-reset A3_E", bus.A3_E, 0);
        check("div-reset A3_M", bus.A3_M, 0);
        check("div-reset A3_W", bus.A3_W, 0);
        check("div-reset RegWrite_W", bus.RegWrite_W, 0);
        check("div-reset md_start_E after", bus.md_start_E, 0);
        @(negedge clk);
        #1;
        check("div-reset mfhi reaches E", bus.A3_E, 8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
